// File: rtl/matrix_pkg.sv
// Shared types and helpers for the trail-scanning 8x8 LED matrix driver.
package matrix_pkg;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int IDX_W = 3;

    typedef enum logic [IDX_W-1:0] {R0, R1, R2, R3, R4, R5, R6, R7} scan_row_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } trail_entry_t;

    // Rows and columns share the same width, so one decoder serves both.
    function automatic logic [COLS-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Row-scan timebase: DIV-cycle prescaler driving an 8-state row counter (R0..R7).
module scan_timer
    import matrix_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    output scan_row_e o_row,
    output logic      o_advance,
    output logic      o_wrap
);

    localparam logic [7:0] LAST = 8'(DIV - 1);

    logic [7:0] r_presc;
    scan_row_e  r_row;
    scan_row_e  w_row_next;
    logic       w_advance;

    assign w_advance = (r_presc == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_advance) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; combinational blocks use blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= R0;
        end else begin
            r_row <= w_row_next;
        end
    end

    // NOTE: a default at the top of every always_comb prevents latch inference.
    always_comb begin
        w_row_next = r_row;
        if (w_advance) begin
            w_row_next = scan_row_e'(3'(r_row + 3'd1));
        end
    end

    always_comb begin
        o_row     = r_row;
        o_advance = w_advance;
        o_wrap    = w_advance && (r_row == R7);
    end

endmodule

// File: rtl/matrix_trail_scan.sv
// Trail-of-positions 8x8 LED matrix scanner with row blanking.
// Define MATRIX_TRAIL_EN for a TRAIL-deep history; otherwise a single dot is shown.
module matrix_trail_scan
    import matrix_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int TRAIL = 4
) (
    input  logic             ck,
    input  logic             reset,
    input  logic [IDX_W-1:0] data1,
    input  logic [IDX_W-1:0] data2,
    output logic [ROWS-1:0]  row_en,
    output logic [COLS-1:0]  col_on,
    output logic             frame_start
);

`ifdef MATRIX_TRAIL_EN
    localparam int DEPTH = TRAIL;
`else
    // Single-entry build: TRAIL does not affect the depth.
    localparam int DEPTH = (TRAIL > 0) ? 1 : 1;
`endif

    trail_entry_t     r_trail [DEPTH];
    logic             r_first;
    scan_row_e        w_row;
    logic             w_advance;
    logic             w_wrap;
    logic [IDX_W-1:0] w_row_inc;
    logic             w_push;
    logic [COLS-1:0]  w_mask;

    scan_timer #(.DIV(DIV)) u_timer (
        .clk       (ck),
        .rst_n     (reset),
        .o_row     (w_row),
        .o_advance (w_advance),
        .o_wrap    (w_wrap)
    );

    assign w_row_inc = 3'(w_row + 3'd1);
    assign w_push    = !r_trail[0].valid ||
                       ({data1, data2} != {r_trail[0].row, r_trail[0].col});

    // NOTE: the trail is a handful of flops, so every entry is reset; larger
    // storage would normally reset only the valid bits.
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_trail[k] <= '0;
            end
        end else if (w_push) begin
            r_trail[0] <= '{valid: 1'b1, row: data1, col: data2};
            for (int k = 1; k < DEPTH; k++) begin
                r_trail[k] <= r_trail[k-1];
            end
        end
    end

    // Duplicate positions deeper in the trail are harmless: masks are ORed.
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_trail[k].valid && (r_trail[k].row == w_row)) begin
                w_mask = w_mask | onehot(r_trail[k].col);
            end
        end
    end

    // Row changes (and the first edge out of reset) blank the columns for a cycle.
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            row_en      <= '0;
            col_on      <= '0;
            frame_start <= 1'b0;
            r_first     <= 1'b1;
        end else if (r_first) begin
            row_en      <= onehot(R0);
            col_on      <= '0;
            frame_start <= 1'b0;
            r_first     <= 1'b0;
        end else if (w_advance) begin
            row_en      <= onehot(w_row_inc);
            col_on      <= '0;
            frame_start <= w_wrap;
        end else begin
            row_en      <= onehot(w_row);
            col_on      <= w_mask;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_matrix_trail_scan.sv
// Scoreboard bench for matrix_trail_scan: two instances (TRAIL=4 and TRAIL=2) share stimulus.
module tb_matrix_trail_scan;

    localparam int DIV = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] d1    = '0;
    logic [2:0] d2    = '0;
    logic [7:0] row_a, col_a, row_b, col_b;
    logic       fs_a, fs_b;

    always #5 clk = ~clk;

    matrix_trail_scan #(.DIV(DIV), .TRAIL(4)) dut_a (
        .ck(clk), .reset(rst_n), .data1(d1), .data2(d2),
        .row_en(row_a), .col_on(col_a), .frame_start(fs_a)
    );

    matrix_trail_scan #(.DIV(DIV), .TRAIL(2)) dut_b (
        .ck(clk), .reset(rst_n), .data1(d1), .data2(d2),
        .row_en(row_b), .col_on(col_b), .frame_start(fs_b)
    );

    typedef struct {
        int         n;
        logic [7:0] row_en;
        logic [7:0] col_a;
        logic [7:0] col_b;
        logic       fs;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   edge_n;

    // Edges since reset release; edge 1 is the first edge after release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", name, act, want);
        end
    endtask

    // Monitor: pops every expectation due at the current edge count.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].n <= edge_n) begin
            e = sb.pop_front();
            if (e.n < edge_n) begin
                total++;
                bad++;
                $display("FAIL missed@%0d: got edge %0d want edge %0d", e.n, edge_n, e.n);
            end else begin
                check($sformatf("row_en_a@%0d", e.n), row_a, e.row_en);
                check($sformatf("row_en_b@%0d", e.n), row_b, e.row_en);
                check($sformatf("col_on_a@%0d", e.n), col_a, e.col_a);
                check($sformatf("col_on_b@%0d", e.n), col_b, e.col_b);
                check($sformatf("frame_a@%0d", e.n), {7'd0, fs_a}, {7'd0, e.fs});
                check($sformatf("frame_b@%0d", e.n), {7'd0, fs_b}, {7'd0, e.fs});
            end
        end
    end

    // Expected outputs after edge n, given the settled per-row masks.
    function automatic exp_t mk(input int n, input logic [7:0] ma[8], input logic [7:0] mb[8]);
        int row;
        bit blank;
        row      = (n / DIV) % 8;
        blank    = (n == 1) || (n % DIV == 0);
        mk.n      = n;
        mk.row_en = 8'h01 << row;
        mk.col_a  = blank ? 8'h00 : ma[row];
        mk.col_b  = blank ? 8'h00 : mb[row];
        mk.fs     = (n % (8 * DIV) == 0);
    endfunction

    // Reset with random inputs, release, then apply len vectors and hold the last one.
    task automatic run(input logic [2:0] rv[4], input logic [2:0] cv[4], input int len,
                       input logic [7:0] ma[8], input logic [7:0] mb[8], input int ncyc);
        exp_t z;
        int   idx;
        rst_n = 1'b0;
        d1    = 3'($urandom_range(0, 7));
        d2    = 3'($urandom_range(0, 7));
        #1;
        z = '{n: 0, row_en: 8'h00, col_a: 8'h00, col_b: 8'h00, fs: 1'b0};
        sb.push_back(z);
        @(negedge clk);
        d1 = 3'($urandom_range(0, 7));
        d2 = 3'($urandom_range(0, 7));
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            idx = (n - 1 < len) ? n - 1 : len - 1;
            d1  = rv[idx];
            d2  = cv[idx];
            if (n == 1 || n > len) sb.push_back(mk(n, ma, mb));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] m_a[8];
        logic [7:0] m_b[8];

        // Static dot (3,5).
        m_a = '{8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
        m_b = m_a;
        run('{3'd3, 3'd0, 3'd0, 3'd0}, '{3'd5, 3'd0, 3'd0, 3'd0}, 1, m_a, m_b, 40);

        // Trail accumulation (1,1),(5,1),(1,2).
`ifdef MATRIX_TRAIL_EN
        m_a = '{8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00};
        m_b = '{8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00};
`else
        m_a = '{8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        m_b = m_a;
`endif
        run('{3'd1, 3'd5, 3'd1, 3'd0}, '{3'd1, 3'd1, 3'd2, 3'd0}, 3, m_a, m_b, 40);

        // Overflow (0,0),(0,1),(0,2); the TRAIL=2 instance drops (0,0).
`ifdef MATRIX_TRAIL_EN
        m_a = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        m_b = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
        m_a = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        m_b = m_a;
`endif
        run('{3'd0, 3'd0, 3'd0, 3'd0}, '{3'd0, 3'd1, 3'd2, 3'd0}, 3, m_a, m_b, 49);

        // Edge 49 leaves row 4 selected (row_en=10); reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_row_en_a", row_a, 8'h00);
        check("async_row_en_b", row_b, 8'h00);
        check("async_col_on_a", col_a, 8'h00);
        check("async_col_on_b", col_b, 8'h00);
        check("async_frame_a", {7'd0, fs_a}, 8'h00);
        check("async_frame_b", {7'd0, fs_b}, 8'h00);

        // Restart with (6,7): the old trail must be gone.
        m_a = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00};
        m_b = m_a;
        run('{3'd6, 3'd0, 3'd0, 3'd0}, '{3'd7, 3'd0, 3'd0, 3'd0}, 1, m_a, m_b, 28);

        @(negedge clk);
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_trail_scan.md
# matrix_trail_scan

- Downstream consumer of the position sequencer's `data1`/`data2` codes.
- Treats `data1` as a row index and `data2` as a column index into an 8x8 LED matrix.
- Keeps a short history (trail) of distinct positions and drives the matrix by row-multiplexed scanning.
- Sits between the sequencer and the board-level row/column drivers.

## Interface

Parameters:
- `DIV`, 4: clock cycles each row stays selected; legal range 2..255.
- `TRAIL`, 4: number of remembered positions; legal range 1..8.

Ports:
- `ck`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data1`  in  3  row code from the sequencer, index 0..7; sampled every cycle.
- `data2`  in  3  column code from the sequencer, index 0..7; sampled every cycle.
- `row_en`  out  8  one-hot row select, active-high, registered.
- `col_on`  out  8  column drive for the selected row, active-high, registered.
- `frame_start`  out  1  one-cycle pulse when scanning wraps to row 0, registered.

One clock; reset is asynchronous and active-low, on ports `ck` and `reset`.

## Operation

- **Trail buffer:** `TRAIL` entries, each {valid, row[2:0], col[2:0]}; entry 0 is the newest.
- **Push rule:** a push occurs on a clock edge when entry 0 is invalid, or when {`data1`,`data2`} differs from entry 0's {row,col}.
  - On a push, entry 0 takes the input and becomes valid; entry k takes entry k-1.
  - The last entry is dropped.
- **No push:** the trail holds.
- **No deduplication beyond entry 0:** a revisited position may occupy several entries. The lit result is the same because column masks are ORed.
- **Scan:** the prescaler counts 0..DIV-1. On the edge where it equals DIV-1, it returns to 0 and the scan row increments modulo 8 (7 wraps to 0).
- **Column mask** for scan row r: the OR over valid entries with row==r of onehot(col). An index value of 0 maps to bit 0.
- **State:** the scan row has 8 states, R0..R7, each visited for exactly `DIV` cycles. There is no other FSM.
- **Simultaneous push and row advance:** both take effect on the same edge. The mask used on the next edge reflects the updated trail.

## Timing

- **Reset values:**
  - `row_en`=8'h00, `col_on`=8'h00, `frame_start`=0.
  - Prescaler=0, scan row=R0, all trail entries invalid.
- **First edge after reset release:**
  - `row_en`=8'h01, `col_on`=8'h00.
  - The trail pushes the current input.
- **Blanking:** on every edge where the scan row changes, and on the first edge after reset, `row_en` takes the new one-hot and `col_on` is forced to 8'h00 for that cycle.
  - Each row therefore shows its pattern for DIV-1 cycles.
- **Mask latency:** on non-blank edges, `col_on` takes the mask computed from the current trail and scan row, giving one cycle of latency from a push to visibility.
- **`frame_start`:** asserts for one cycle on the same edge `row_en` becomes 8'h01 because of a 7→0 wrap. It does not assert on the first edge after reset. Period is 8·DIV cycles.
- **Reset mid-operation:** all state and outputs return to their reset values immediately, with no wait for a clock edge. No partial frame is completed.

## Configuration

- **`MATRIX_TRAIL_EN` defined:** full trail of `TRAIL` entries as described above.
- **`MATRIX_TRAIL_EN` undefined:**
  - Only entry 0 exists and the `TRAIL` parameter is ignored.
  - The matrix shows a single dot at the latest position.
  - Push rule, scan, blanking and `frame_start` timing are unchanged.

## Structure

- **Shared package `matrix_pkg`:**
  - `ROWS`=8, `COLS`=8 and `IDX_W`=3.
  - Trail-entry struct type {valid, row, col}.
  - One-hot decode function.
- **Sub-module `scan_timer`:**
  - Contains the prescaler and row counter.
  - Outputs the scan row index, a row-advance strobe and a wrap strobe.
  - Parameterised by `DIV`.
- **`matrix_trail_scan` itself:** trail buffer, mask OR-reduction and output registers.

## Test plan

- **Reset:** hold `reset`=0 with random inputs → `row_en`=00, `col_on`=00, `frame_start`=0. Release → first edge gives `row_en`=01, `col_on`=00.
- **Static dot:** DIV=4, `data1`=3, `data2`=5 held → in the three non-blank cycles of `row_en`=08, `col_on`=20; all other rows show `col_on`=00. The trail holds one valid entry.
- **Trail accumulation:** TRAIL=4, inputs (1,1),(5,1),(1,2), then held → row 1 shows `col_on`=06, row 5 shows `col_on`=02. Without `MATRIX_TRAIL_EN`: only row 1 shows `col_on`=04.
- **Overflow:** TRAIL=2, inputs (0,0),(0,1),(0,2) → row 0 shows `col_on`=06; bit 0 is cleared because the oldest entry was dropped.
- **Wrap:** DIV=4 → `frame_start` pulses every 32 cycles, coincident with `row_en` 80→01 and `col_on`=00.
- **Reset mid-scan:** assert `reset` while `row_en`=10 → outputs clear asynchronously. After release the scan restarts at row 0 and the trail holds only the new input.
